// File: rtl/pe_pkg.sv
// Shared constants and FSM encoding for the serial_pe line feeder.
// The feeder turns SRAM lines into a bubble-free stream of neuron/weight element pairs.
package pe_pkg;
  localparam int DATA_W = 16;
  localparam int LANES  = 32;
  localparam int LINE_W = DATA_W * LANES;
  localparam int ADDR_W = 11;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_e;
endpackage

// File: rtl/pe_line_feeder_line_serializer.sv
// Active/shadow line buffer that presents one element per cycle, MSB element first.
// A swap that coincides with a load takes the incoming line straight into the active buffer.
module line_serializer
  import pe_pkg::*;
#(
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int LANES  = pe_pkg::LANES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_shadow,
  input  logic                    swap,
  input  logic                    shift,
  input  logic [DATA_W*LANES-1:0] line_i,
  output logic [DATA_W-1:0]       elem_o
);
  localparam int LW = DATA_W * LANES;

  logic [LW-1:0] active_q;
  logic [LW-1:0] shadow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
      shadow_q <= '0;
    end else begin
      if (load_shadow) shadow_q <= line_i;
      if (swap) active_q <= load_shadow ? line_i : shadow_q;
      else if (shift) active_q <= {active_q[LW-DATA_W-1:0], {DATA_W{1'b0}}};
    end
  end

  assign elem_o = active_q[LW-1 -: DATA_W];
endmodule

// File: rtl/pe_line_feeder.sv
// Feeds serial_pe with element pairs from paired neuron/weight SRAM lines.
// The next line (or next instruction's first line) is prefetched while element 0 is presented.
module pe_line_feeder
  import pe_pkg::*;
#(
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int LANES  = pe_pkg::LANES,
  parameter int ADDR_W = pe_pkg::ADDR_W,
  parameter int LEN_W  = pe_pkg::LEN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inst_vld,
  output logic                    inst_rdy,
  input  logic [ADDR_W-1:0]       inst_base,
  input  logic [LEN_W-1:0]        inst_len,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [DATA_W*LANES-1:0] rd_neuron,
  input  logic [DATA_W*LANES-1:0] rd_weight,
  output logic [DATA_W-1:0]       pe_neuron,
  output logic [DATA_W-1:0]       pe_weight,
  output logic [1:0]              pe_ctl,
  output logic                    pe_vld,
  output logic                    busy
);
  localparam int EW = $clog2(LANES);
  localparam logic [EW-1:0] ELEM_LAST = EW'(LANES - 1);
  localparam logic [EW-1:0] ELEM_PEN  = EW'(LANES - 2);

  state_e              state_q;
  logic [ADDR_W-1:0]   base_q, nxt_base_q, rd_addr_q;
  logic [LEN_W-1:0]    len_q, nxt_len_q, line_q;
  logic [EW-1:0]       elem_q;
  logic                nxt_vld_q, rd_en_q, rd_dv_q, pe_vld_q, busy_q;
  logic [1:0]          pe_ctl_q;

  logic                last_line_d, slot_d, accept_d;
  logic                ser_load_d, ser_swap_d, ser_shift_d;
  logic [ADDR_W-1:0]   next_addr_d;

  assign last_line_d = (line_q == len_q - LEN_W'(1));
  // The only in-stream acceptance window: element 0 of the last line.
  assign slot_d      = (state_q == STREAM) && (elem_q == '0) && last_line_d;
  assign inst_rdy    = (state_q == IDLE) || slot_d;
  assign accept_d    = inst_vld && inst_rdy && (inst_len != '0);
  assign next_addr_d = base_q + ADDR_W'(line_q) + ADDR_W'(1);

  assign ser_load_d  = rd_dv_q;
  assign ser_swap_d  = ((state_q == FETCH) && rd_dv_q) ||
                       ((state_q == STREAM) && (elem_q == ELEM_LAST));
  assign ser_shift_d = (state_q == STREAM) && (elem_q != ELEM_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      line_q     <= '0;
      elem_q     <= '0;
      nxt_vld_q  <= 1'b0;
      nxt_base_q <= '0;
      nxt_len_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_dv_q    <= 1'b0;
      pe_vld_q   <= 1'b0;
      pe_ctl_q   <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      rd_dv_q <= rd_en_q;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            base_q    <= inst_base;
            len_q     <= inst_len;
            rd_en_q   <= 1'b1;
            rd_addr_q <= inst_base;
            busy_q    <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          if (rd_dv_q) begin
            state_q  <= STREAM;
            pe_vld_q <= 1'b1;
            pe_ctl_q <= 2'b01;
            elem_q   <= '0;
            line_q   <= '0;
          end
        end
        STREAM: begin
          if (elem_q == '0) begin
            if (!last_line_d) begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= next_addr_d;
            end else if (accept_d) begin
              nxt_vld_q  <= 1'b1;
              nxt_base_q <= inst_base;
              nxt_len_q  <= inst_len;
              rd_en_q    <= 1'b1;
              rd_addr_q  <= inst_base;
            end
          end
          if (elem_q != ELEM_LAST) begin
            elem_q   <= elem_q + EW'(1);
            pe_ctl_q <= {last_line_d && (elem_q == ELEM_PEN), 1'b0};
          end else begin
            elem_q <= '0;
            if (!last_line_d) begin
              line_q   <= line_q + LEN_W'(1);
              pe_ctl_q <= 2'b00;
            end else if (nxt_vld_q) begin
              base_q    <= nxt_base_q;
              len_q     <= nxt_len_q;
              line_q    <= '0;
              nxt_vld_q <= 1'b0;
              pe_ctl_q  <= 2'b01;
            end else begin
              pe_vld_q <= 1'b0;
              pe_ctl_q <= 2'b00;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  line_serializer #(.DATA_W(DATA_W), .LANES(LANES)) u_ser_neuron (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_shadow (ser_load_d),
    .swap        (ser_swap_d),
    .shift       (ser_shift_d),
    .line_i      (rd_neuron),
    .elem_o      (pe_neuron)
  );

  line_serializer #(.DATA_W(DATA_W), .LANES(LANES)) u_ser_weight (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_shadow (ser_load_d),
    .swap        (ser_swap_d),
    .shift       (ser_shift_d),
    .line_i      (rd_weight),
    .elem_o      (pe_weight)
  );

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign pe_vld  = pe_vld_q;
  assign pe_ctl  = pe_ctl_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_pe_line_feeder.sv
// Scoreboard bench for pe_line_feeder: expected reads, elements, start cycles and dot products
// are queued when an instruction is accepted and retired as the DUT produces them.
module tb_pe_line_feeder;
  import pe_pkg::*;

  localparam int LW = DATA_W * LANES;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              inst_vld = 1'b0;
  logic              inst_rdy;
  logic [ADDR_W-1:0] inst_base = '0;
  logic [LEN_W-1:0]  inst_len = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [LW-1:0]     rd_neuron = '0;
  logic [LW-1:0]     rd_weight = '0;
  logic [DATA_W-1:0] pe_neuron, pe_weight;
  logic [1:0]        pe_ctl;
  logic              pe_vld;
  logic              busy;

  pe_line_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst_vld  (inst_vld),
    .inst_rdy  (inst_rdy),
    .inst_base (inst_base),
    .inst_len  (inst_len),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_neuron (rd_neuron),
    .rd_weight (rd_weight),
    .pe_neuron (pe_neuron),
    .pe_weight (pe_weight),
    .pe_ctl    (pe_ctl),
    .pe_vld    (pe_vld),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [LW-1:0] nmem [0:2047];
  logic [LW-1:0] wmem [0:2047];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_neuron <= nmem[rd_addr];
      rd_weight <= wmem[rd_addr];
    end
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] n;
    logic [15:0] w;
    logic [1:0]  c;
  } exp_t;

  exp_t              sbq[$];
  logic [ADDR_W-1:0] rdq[$];
  longint            startq[$];
  longint            dotq[$];
  longint            runs[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_inst(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l, input bit idle);
    longint dot = 0;
    logic [LW-1:0] nl, wl;
    logic [ADDR_W-1:0] a;
    exp_t e;
    if (l == 0) return;
    startq.push_back(idle ? cyc + 3 : -1);
    for (int i = 0; i < int'(l); i++) begin
      a = b + ADDR_W'(i);
      rdq.push_back(a);
      nl = nmem[a];
      wl = wmem[a];
      for (int k = 0; k < LANES; k++) begin
        e.n = nl[16*(31-k) +: 16];
        e.w = wl[16*(31-k) +: 16];
        e.c = {(i == int'(l) - 1) && (k == 31), (i == 0) && (k == 0)};
        dot += longint'($signed(e.n)) * longint'($signed(e.w));
        sbq.push_back(e);
      end
    end
    dotq.push_back(dot);
  endtask

  task automatic send(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
    int n = 0;
    bit idle;
    inst_vld = 1'b1;
    inst_base = b;
    inst_len = l;
    while (!inst_rdy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", longint'(n < 3000), 1);
    idle = (busy == 1'b0);
    if (n < 3000) push_inst(b, l, idle);
    @(posedge clk);
    #1;
    inst_vld = 1'b0;
    if (idle && l != 0) check("busy_T1", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    bit done = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
      if (sbq.size() == 0 && !busy) done = 1;
    end
    check("drain_timeout", longint'(done), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_run(input string tag, input longint exp);
    if (runs.size() != 0) check(tag, runs.pop_front(), exp);
    else check(tag, -1, exp);
  endtask

  // Output monitor
  exp_t   m_e;
  longint run = 0;
  longint vld_total = 0;
  longint acc = 0;
  longint last_c1 = -10;
  longint st;

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (rd_en) begin
        if (rdq.size() != 0) check("rd_addr", rd_addr, rdq.pop_front());
        else check("unexpected_rd", 1, 0);
      end
      if (pe_vld) begin
        vld_total++;
        run++;
        check("busy_stream", busy, 1);
        if (sbq.size() != 0) begin
          m_e = sbq.pop_front();
          check("pe_neuron", pe_neuron, m_e.n);
          check("pe_weight", pe_weight, m_e.w);
          check("pe_ctl", pe_ctl, m_e.c);
        end else begin
          check("unexpected_vld", 1, 0);
        end
        if (pe_ctl[0]) begin
          acc = 0;
          if (startq.size() != 0) begin
            st = startq.pop_front();
            if (st >= 0) check("start_latency", cyc, st);
            else check("b2b_gap", cyc, last_c1 + 1);
          end else begin
            check("unexpected_start", 1, 0);
          end
        end
        acc += longint'($signed(pe_neuron)) * longint'($signed(pe_weight));
        if (pe_ctl[1]) begin
          last_c1 = cyc;
          if (dotq.size() != 0) check("dot_product", acc, dotq.pop_front());
          else check("unexpected_last", 1, 0);
        end
      end else if (run != 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
  end

  initial begin
    longint tgt;
    int n;
    for (int a = 0; a < 2048; a++) begin
      for (int k = 0; k < LANES; k++) begin
        nmem[a][16*(31-k) +: 16] = 16'(a * 32 + k + 1);
        wmem[a][16*(31-k) +: 16] = 16'((a * 37 + k * 1009) ^ 16'h5A5A);
      end
    end

    repeat (3) @(negedge clk);
    check("rst_inst_rdy", inst_rdy, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_pe_vld", pe_vld, 0);
    check("rst_pe_ctl", pe_ctl, 0);
    check("rst_busy", busy, 0);
    check("rst_pe_neuron", pe_neuron, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(11'h000, 8'd1);
    wait_done();
    chk_run("run_len1", 32);

    send(11'h010, 8'd4);
    wait_done();
    chk_run("run_len4", 128);

    send(11'h020, 8'd2);
    send(11'h030, 8'd3);
    wait_done();
    chk_run("run_b2b", 160);

    send(11'h040, 8'd0);
    repeat (10) @(negedge clk);
    send(11'h050, 8'd1);
    send(11'h060, 8'd0);
    send(11'h070, 8'd1);
    wait_done();
    chk_run("run_null_a", 32);
    chk_run("run_null_b", 32);

    send(11'h7FF, 8'd2);
    wait_done();
    chk_run("run_wrap", 64);

    send(11'h100, 8'd3);
    tgt = vld_total + 42;
    n = 0;
    while (vld_total < tgt && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("midreset_reach", longint'(vld_total >= tgt), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_pe_vld", pe_vld, 0);
    check("mrst_pe_ctl", pe_ctl, 0);
    check("mrst_rd_en", rd_en, 0);
    check("mrst_rd_addr", rd_addr, 0);
    check("mrst_busy", busy, 0);
    check("mrst_inst_rdy", inst_rdy, 1);
    check("mrst_pe_neuron", pe_neuron, 0);
    check("mrst_pe_weight", pe_weight, 0);
    sbq.delete();
    rdq.delete();
    startq.delete();
    dotq.delete();
    runs.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(11'h200, 8'd1);
    wait_done();
    chk_run("run_after_reset", 32);

    send(11'h300, 8'd1);
    send(11'h301, 8'd2);
    send(11'h303, 8'd3);
    send(11'h306, 8'd4);
    wait_done();
    chk_run("run_chain", 320);
    check("chain_dots_left", dotq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
